// File: rtl/block_mult_scheduler_pkg.sv
// Shared types and constants for the block-multiply tile scheduler.
package block_mult_scheduler_pkg;

  localparam int TILE_DIM    = 4;
  localparam int FEED_CYCLES = TILE_DIM;
  localparam int SKEW_CYCLES = 3;
  localparam int IDX_W       = 3;
  localparam int CFG_W       = 4;
  localparam int PH_W        = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FEED   = 3'd2,
    ST_SKEW   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  // Tile counts must fit the 3-bit tile indices: 1..8.
  function automatic logic cfg_ok(input logic [CFG_W-1:0] v);
    return (v != '0) && (v <= CFG_W'(8));
  endfunction

endpackage

// File: rtl/block_mult_scheduler_tile_index_counter.sv
// Nested i/j/k tile counter: k is innermost, then j, then i.
module tile_index_counter
  import block_mult_scheduler_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_k,
  input  logic             inc_tile,
  input  logic [CFG_W-1:0] cfg_m,
  input  logic [CFG_W-1:0] cfg_n,
  input  logic [CFG_W-1:0] cfg_k,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k,
  output logic             last_k,
  output logic             last_tile
);

  logic last_i;
  logic last_j;

  assign last_i    = ({1'b0, i} == cfg_m - CFG_W'(1));
  assign last_j    = ({1'b0, j} == cfg_n - CFG_W'(1));
  assign last_k    = ({1'b0, k} == cfg_k - CFG_W'(1));
  assign last_tile = last_i && last_j;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clear) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (inc_tile) begin
      // Finishing a result tile restarts the inner reduction.
      k <= '0;
      if (last_j) begin
        j <= '0;
        i <= last_i ? '0 : i + IDX_W'(1);
      end else begin
        j <= j + IDX_W'(1);
      end
    end else if (inc_k) begin
      k <= k + IDX_W'(1);
    end
  end

endmodule

// File: rtl/block_mult_scheduler.sv
// Sequences operand fetch, systolic feed/skew, pass wait and result write per tile.
module block_mult_scheduler
  import block_mult_scheduler_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_m,
  input  logic [CFG_W-1:0] cfg_n,
  input  logic [CFG_W-1:0] cfg_k,
  input  logic             abort,
  output logic             rd_req,
  input  logic             rd_ack,
  output logic [IDX_W-1:0] a_row,
  output logic [IDX_W-1:0] b_col,
  output logic [IDX_W-1:0] k_idx,
  output logic [1:0]       feed_sel,
  output logic             feed_en,
  output logic             feed_zero,
  output logic             arr_clr_n,
  input  logic             arr_done,
  output logic             wr_req,
  input  logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  // Handshakes: rd_req/wr_req rise with their tile indices and hold them
  // unchanged until the cycle rd_ack/wr_ready is high; the transfer completes
  // on that rising edge. abort in the same cycle wins and drops the request.

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CFG_W-1:0]  cfg_m_q, cfg_n_q, cfg_k_q;
  logic              err_q, err_d;
  logic              clr_n_q, clr_n_d;
  logic              load_cfg, clear, inc_k, inc_tile, kill;
  logic              last_k, last_tile;

  tile_index_counter u_idx (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .inc_k     (inc_k),
    .inc_tile  (inc_tile),
    .cfg_m     (cfg_m_q),
    .cfg_n     (cfg_n_q),
    .cfg_k     (cfg_k_q),
    .i         (a_row),
    .j         (b_col),
    .k         (k_idx),
    .last_k    (last_k),
    .last_tile (last_tile)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cfg_m_q <= '0;
      cfg_n_q <= '0;
      cfg_k_q <= '0;
      err_q   <= 1'b0;
      clr_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      err_q   <= err_d;
      clr_n_q <= clr_n_d;
      if (load_cfg) begin
        cfg_m_q <= cfg_m;
        cfg_n_q <= cfg_n;
        cfg_k_q <= cfg_k;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = '0;
    err_d     = err_q;
    load_cfg  = 1'b0;
    clear     = 1'b0;
    inc_k     = 1'b0;
    inc_tile  = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    feed_en   = 1'b0;
    feed_zero = 1'b0;
    feed_sel  = 2'd0;
    done      = 1'b0;
    kill      = abort && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          clear    = 1'b1;
          if (cfg_ok(cfg_m) && cfg_ok(cfg_n) && cfg_ok(cfg_k)) begin
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end
      ST_LOAD: begin
        rd_req = 1'b1;
        if (rd_ack) state_d = ST_FEED;
      end
      ST_FEED: begin
        feed_en  = 1'b1;
        feed_sel = phase_q;
        if (phase_q == PH_W'(FEED_CYCLES - 1)) state_d = ST_SKEW;
        else phase_d = phase_q + PH_W'(1);
      end
      ST_SKEW: begin
        feed_en   = 1'b1;
        feed_zero = 1'b1;
        if (phase_q == PH_W'(SKEW_CYCLES - 1)) state_d = ST_WAIT;
        else phase_d = phase_q + PH_W'(1);
      end
      ST_WAIT: begin
        if (arr_done) begin
          if (last_k) begin
            state_d = ST_WRITE;
          end else begin
            inc_k   = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_WRITE: begin
        wr_req = 1'b1;
        if (wr_ready) begin
          inc_tile = 1'b1;
          state_d  = last_tile ? ST_FINISH : ST_LOAD;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (kill) begin
      state_d   = ST_IDLE;
      phase_d   = '0;
      inc_k     = 1'b0;
      inc_tile  = 1'b0;
      rd_req    = 1'b0;
      wr_req    = 1'b0;
      feed_en   = 1'b0;
      feed_zero = 1'b0;
      feed_sel  = 2'd0;
      done      = 1'b0;
    end

    // Clear pulse covers only the first LOAD cycle of a tile (k restarts at 0).
    clr_n_d = !(((state_q == ST_IDLE) || (state_q == ST_WRITE)) && (state_d == ST_LOAD));
  end

  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign arr_clr_n = clr_n_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_block_mult_scheduler.sv
// Directed bench for block_mult_scheduler with a cycle-level handshake responder.
module tb_block_mult_scheduler;
  import block_mult_scheduler_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       rd_ack = 1'b0;
  logic       arr_done = 1'b0;
  logic       wr_ready = 1'b0;
  logic [3:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
  logic       rd_req, wr_req, feed_en, feed_zero, arr_clr_n, busy, done, err;
  logic [2:0] a_row, b_col, k_idx, dbg_state;
  logic [1:0] feed_sel;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  block_mult_scheduler dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .cfg_m     (cfg_m),
    .cfg_n     (cfg_n),
    .cfg_k     (cfg_k),
    .abort     (abort),
    .rd_req    (rd_req),
    .rd_ack    (rd_ack),
    .a_row     (a_row),
    .b_col     (b_col),
    .k_idx     (k_idx),
    .feed_sel  (feed_sel),
    .feed_en   (feed_en),
    .feed_zero (feed_zero),
    .arr_clr_n (arr_clr_n),
    .arr_done  (arr_done),
    .wr_req    (wr_req),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Job log filled by run_job; {a_row,b_col,k_idx,arr_clr_n} per fetch.
  logic [9:0] fetch_q[$];
  logic [9:0] exp_q[$];
  logic [5:0] wr_q[$];
  logic [2:0] feed_q[$];
  int   done_cyc, done_cnt, end_cyc, rd_cnt, wr_cnt, rd_hi_cyc;
  int   clr_low_cnt, hold_bad, feed_in_load, timeout;
  logic err_at_done, ab_feed_en, ab_rd_req, ab_done;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_job(input logic [3:0] m, input logic [3:0] n, input logic [3:0] k,
                         input int ack_dly, input int wr_dly, input int abort_at);
    int cyc, rq_age, wq_age;
    logic prev_rd, prev_wr, prev_zero;
    logic [8:0] held_rd;
    logic [5:0] held_wr;
    fetch_q.delete(); wr_q.delete(); feed_q.delete();
    done_cyc = -1; done_cnt = 0; end_cyc = -1; rd_cnt = 0; wr_cnt = 0; rd_hi_cyc = 0;
    clr_low_cnt = 0; hold_bad = 0; feed_in_load = 0; timeout = 0;
    err_at_done = 1'b0; ab_feed_en = 1'b1; ab_rd_req = 1'b1; ab_done = 1'b1;
    cfg_m = m; cfg_n = n; cfg_k = k;
    rd_ack = 0; wr_ready = 0; arr_done = 0; abort = 0;
    start = 1;
    step();
    start = 0;
    cyc = 1; rq_age = 0; wq_age = 0;
    prev_rd = 0; prev_wr = 0; prev_zero = 0; held_rd = '0; held_wr = '0;
    while (busy) begin
      if (cyc > 3000) begin
        timeout = 1;
        break;
      end
      if (rd_req) begin
        rd_hi_cyc++;
        if (!prev_rd) begin
          rd_cnt++;
          rq_age = 0;
          held_rd = {a_row, b_col, k_idx};
          fetch_q.push_back({a_row, b_col, k_idx, arr_clr_n});
        end else if ({a_row, b_col, k_idx} != held_rd) hold_bad++;
        rq_age++;
        if (feed_en) feed_in_load++;
      end
      if (wr_req) begin
        if (!prev_wr) begin
          wr_cnt++;
          wq_age = 0;
          held_wr = {a_row, b_col};
          wr_q.push_back(held_wr);
        end else if ({a_row, b_col} != held_wr) hold_bad++;
        wq_age++;
      end
      if (feed_en) feed_q.push_back({feed_zero, feed_sel});
      if (!arr_clr_n) clr_low_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        err_at_done = err;
      end
      rd_ack   = rd_req && (rq_age > ack_dly);
      wr_ready = wr_req && (wq_age > wr_dly);
      arr_done = prev_zero && !feed_en;
      abort    = (cyc == abort_at);
      if (abort) begin
        #1;
        ab_feed_en = feed_en;
        ab_rd_req  = rd_req;
        ab_done    = done;
      end
      prev_rd = rd_req; prev_wr = wr_req; prev_zero = feed_zero;
      step();
      cyc++;
    end
    end_cyc = cyc;
    rd_ack = 0; wr_ready = 0; arr_done = 0; abort = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    #12;
    checks++;
    if (busy !== 1'b0 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state: busy=%b state=%0d expected busy=0 state=0", busy, dbg_state);
    end
    checks++;
    if ({rd_req, wr_req, feed_en, feed_zero, done, err, arr_clr_n} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000000",
                         {rd_req, wr_req, feed_en, feed_zero, done, err, arr_clr_n});
    end
    checks++;
    if ({a_row, b_col, k_idx, feed_sel} !== 11'b0) begin
      errors++; $display("FAIL reset_indices: got %h expected 000", {a_row, b_col, k_idx, feed_sel});
    end
    @(negedge clock);
    reset = 1;
    step();
    checks++;
    if (arr_clr_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: arr_clr_n=%b busy=%b expected 1 0", arr_clr_n, busy);
    end
  endtask

  task automatic test_single();
    logic ok;
    run_job(4'd1, 4'd1, 4'd1, 0, 0, -1);
    checks++;
    if (timeout !== 0 || done_cyc !== 11) begin
      errors++; $display("FAIL single_latency: done at %0d (timeout %0d) expected 11", done_cyc, timeout);
    end
    checks++;
    if (rd_cnt !== 1 || wr_cnt !== 1 || done_cnt !== 1) begin
      errors++; $display("FAIL single_counts: rd %0d wr %0d done %0d expected 1 1 1", rd_cnt, wr_cnt, done_cnt);
    end
    checks++;
    if (err_at_done !== 1'b0 || clr_low_cnt !== 1) begin
      errors++; $display("FAIL single_err_clr: err %b clr_low %0d expected 0 1", err_at_done, clr_low_cnt);
    end
    checks++;
    if (fetch_q.size() != 1 || fetch_q[0] !== 10'b0) begin
      errors++; $display("FAIL single_fetch: size %0d expected one zero-index fetch with clear", fetch_q.size());
    end
    ok = (feed_q.size() == 7);
    for (int p = 0; p < 7 && ok; p++) begin
      if (feed_q[p] !== ((p < 4) ? 3'(p) : 3'b100)) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_feed_seq: %0d entries, expected sel 0,1,2,3 then 3 zero cycles", feed_q.size());
    end
  endtask

  task automatic test_2x2x2();
    logic [5:0] exp_w;
    run_job(4'd2, 4'd2, 4'd2, 0, 0, -1);
    exp_q.delete();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 2; k++)
          exp_q.push_back({3'(i), 3'(j), 3'(k), (k != 0)});
    checks++;
    if (fetch_q.size() != 8) begin
      errors++; $display("FAIL m2_fetch_count: got %0d expected 8", fetch_q.size());
    end
    for (int e = 0; e < 8 && e < fetch_q.size(); e++) begin
      checks++;
      if (fetch_q[e] !== exp_q[e]) begin
        errors++; $display("FAIL m2_fetch_%0d: got %b expected %b", e, fetch_q[e], exp_q[e]);
      end
    end
    checks++;
    if (wr_cnt !== 4 || clr_low_cnt !== 4 || done_cyc !== 77) begin
      errors++; $display("FAIL m2_totals: wr %0d clr_low %0d done %0d expected 4 4 77", wr_cnt, clr_low_cnt, done_cyc);
    end
    for (int w = 0; w < 4 && w < wr_q.size(); w++) begin
      exp_w = {3'(w / 2), 3'(w % 2)};
      checks++;
      if (wr_q[w] !== exp_w) begin
        errors++; $display("FAIL m2_write_%0d: got %b expected %b", w, wr_q[w], exp_w);
      end
    end
  endtask

  task automatic test_bad_cfg();
    run_job(4'd1, 4'd1, 4'd0, 0, 0, -1);
    checks++;
    if (done_cyc !== 1 || err_at_done !== 1'b1 || rd_cnt !== 0 || end_cyc !== 2) begin
      errors++; $display("FAIL bad_k0: done %0d err %b rd %0d end %0d expected 1 1 0 2",
                         done_cyc, err_at_done, rd_cnt, end_cyc);
    end
    repeat (3) step();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL bad_sticky: err %b expected 1", err);
    end
    run_job(4'd9, 4'd1, 4'd1, 0, 0, -1);
    checks++;
    if (err_at_done !== 1'b1 || rd_cnt !== 0 || done_cyc !== 1) begin
      errors++; $display("FAIL bad_m9: err %b rd %0d done %0d expected 1 0 1", err_at_done, rd_cnt, done_cyc);
    end
    run_job(4'd1, 4'd1, 4'd1, 0, 0, -1);
    checks++;
    if (err !== 1'b0 || err_at_done !== 1'b0 || done_cyc !== 11) begin
      errors++; $display("FAIL bad_recover: err %b done %0d expected 0 11", err, done_cyc);
    end
  endtask

  task automatic test_stall();
    run_job(4'd2, 4'd1, 4'd1, 5, 3, -1);
    checks++;
    if (hold_bad !== 0 || feed_in_load !== 0) begin
      errors++; $display("FAIL stall_hold: index changes %0d feed in load %0d expected 0 0", hold_bad, feed_in_load);
    end
    checks++;
    if (rd_cnt !== 2 || wr_cnt !== 2 || rd_hi_cyc !== 12 || done_cyc !== 37) begin
      errors++; $display("FAIL stall_timing: rd %0d wr %0d rd_high %0d done %0d expected 2 2 12 37",
                         rd_cnt, wr_cnt, rd_hi_cyc, done_cyc);
    end
    checks++;
    if (fetch_q.size() != 2 || fetch_q[1] !== {3'd1, 3'd0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL stall_second_fetch: size %0d expected row 1 fetch with clear", fetch_q.size());
    end
  endtask

  task automatic test_abort();
    run_job(4'd1, 4'd1, 4'd1, 0, 0, 3);
    checks++;
    if (ab_feed_en !== 1'b0 || done_cnt !== 0 || end_cyc !== 4) begin
      errors++; $display("FAIL abort_feed: feed_en %b done %0d idle at %0d expected 0 0 4",
                         ab_feed_en, done_cnt, end_cyc);
    end
    run_job(4'd1, 4'd1, 4'd1, 0, 0, 1);
    checks++;
    if (ab_rd_req !== 1'b0 || end_cyc !== 2 || feed_q.size() != 0 || done_cnt !== 0) begin
      errors++; $display("FAIL abort_over_ack: rd_req %b idle at %0d feeds %0d done %0d expected 0 2 0 0",
                         ab_rd_req, end_cyc, feed_q.size(), done_cnt);
    end
    run_job(4'd1, 4'd1, 4'd1, 0, 0, -1);
    checks++;
    if (done_cyc !== 11 || done_cnt !== 1 || clr_low_cnt !== 1) begin
      errors++; $display("FAIL abort_restart: done %0d pulses %0d clr_low %0d expected 11 1 1",
                         done_cyc, done_cnt, clr_low_cnt);
    end
  endtask

  task automatic test_reset_wait();
    cfg_m = 4'd1; cfg_n = 4'd1; cfg_k = 4'd1;
    start = 1;
    step();
    start = 0; rd_ack = 1; wr_ready = 1;
    repeat (8) step();
    checks++;
    if (dbg_state !== 3'd4) begin
      errors++; $display("FAIL rst_wait_reach: state %0d expected 4", dbg_state);
    end
    #2;
    reset = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || {rd_req, wr_req, feed_en, feed_zero, done, err, arr_clr_n} !== 7'b0) begin
      errors++; $display("FAIL rst_wait_outputs: busy %b outs %b expected 0 0000000",
                         busy, {rd_req, wr_req, feed_en, feed_zero, done, err, arr_clr_n});
    end
    checks++;
    if ({a_row, b_col, k_idx, feed_sel} !== 11'b0) begin
      errors++; $display("FAIL rst_wait_indices: got %h expected 000", {a_row, b_col, k_idx, feed_sel});
    end
    @(negedge clock);
    reset = 1; rd_ack = 0; wr_ready = 0; arr_done = 1;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_req !== 1'b0) begin
        errors++; $display("FAIL rst_stray_done_%0d: busy %b done %b wr_req %b expected 0 0 0",
                           s, busy, done, wr_req);
      end
    end
    arr_done = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_2x2x2();
    test_bad_cfg();
    test_stall();
    test_abort();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
